// File: rtl/mem_port_arbiter_if.sv
// Request/grant bundle between the four memory-port requesters and the arbiter.
// The arbiter uses the master side; requesters and the shared port use the slave side.
interface mem_port_arbiter_if;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic       timeout;

  modport master (
    input  req,
    input  done,
    output gnt,
    output sel,
    output busy,
    output timeout
  );

  modport slave (
    output req,
    output done,
    input  gnt,
    input  sel,
    input  busy,
    input  timeout
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin 4-way arbiter for the shared 32-bit memory port; grant follows req by 1 cycle.
// A grant is held until done, requester withdrawal, or MAX_HOLD cycles; arbitration only in IDLE.
module mem_port_arbiter #(
  parameter  int MAX_HOLD = 16,
  localparam int CNT_W    = $clog2(MAX_HOLD + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_port_arbiter_if.master    bus
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [1:0]       sel_q, sel_d;
  logic             busy_q, busy_d;
  logic             timeout_q, timeout_d;

  logic             found;
  logic [1:0]       pick;
  logic [1:0]       idx;
  logic             req_k;
  logic             hold_expired;

  // First requester at or after ptr, wrapping 3->0.
  always_comb begin
    found = 1'b0;
    pick  = ptr_q;
    idx   = ptr_q;
    for (int i = 0; i < 4; i++) begin
      idx = ptr_q + 2'(i);
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign req_k        = bus.req[sel_q];
  assign hold_expired = (cnt_q == HOLD_LAST);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = BUSY;
          gnt_d   = 4'b0001 << pick;
          sel_d   = pick;
          busy_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        if (bus.done || !req_k || hold_expired) begin
          // sel is left at k so the port mux stays stable through the idle cycle.
          state_d   = IDLE;
          gnt_d     = 4'b0000;
          busy_d    = 1'b0;
          ptr_d     = sel_q + 2'd1;
          timeout_d = !bus.done && req_k && hold_expired;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= 2'd0;
      cnt_q     <= '0;
      gnt_q     <= 4'b0000;
      sel_q     <= 2'd0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      sel_q     <= sel_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.sel     = sel_q;
  assign bus.busy    = busy_q;
  assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios then random traffic, all cycles
// checked against a grant-ownership model.
module tb_mem_port_arbiter;
  localparam int MH = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.MAX_HOLD(MH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Model: who owns the port (-1 = nobody), how many cycles it has held gnt,
  // where the next search starts, the last mux select, and the timeout pulse.
  int         m_owner = -1;
  int         m_age   = 0;
  int         m_ptr   = 0;
  int         m_sel   = 0;
  logic       m_to    = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_update(input logic [3:0] r, input logic d, input logic rs);
    int k;
    if (rs) begin
      m_owner = -1; m_age = 0; m_ptr = 0; m_sel = 0; m_to = 1'b0;
    end else if (m_owner < 0) begin
      m_to = 1'b0;
      if (r != 4'b0000) begin
        for (int i = 0; i < 4; i++) begin
          k = (m_ptr + i) % 4;
          if (m_owner < 0 && r[k]) m_owner = k;
        end
        m_sel = m_owner;
        m_age = 1;
      end
    end else begin
      m_to = 1'b0;
      if (d || !r[m_owner] || m_age == MH) begin
        m_to    = !d && r[m_owner] && (m_age == MH);
        m_ptr   = (m_owner + 1) % 4;
        m_owner = -1;
      end else begin
        m_age++;
      end
    end
  endtask

  task automatic step(input logic [3:0] r, input logic d, input logic rs);
    logic [3:0] eg;
    bus.req  = r;
    bus.done = d;
    rst      = rs;
    model_update(r, d, rs);
    @(posedge clk);
    #1;
    eg = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
    chk("gnt",     32'(bus.gnt),     32'(eg));
    chk("sel",     32'(bus.sel),     32'(m_sel));
    chk("busy",    32'(bus.busy),    32'(m_owner >= 0));
    chk("timeout", 32'(bus.timeout), 32'(m_to));
    chk("inv_onehot0",  32'($onehot0(bus.gnt)), 32'd1);
    chk("inv_busy_or",  32'(bus.busy == |bus.gnt), 32'd1);
    chk("inv_to_busy",  32'(bus.timeout && bus.busy), 32'd0);
  endtask

  int         hi_cnt;
  int         to_cnt;
  logic [3:0] cur_req;
  logic       cur_done;
  logic       cur_rst;

  initial begin
    bus.req  = 4'b0000;
    bus.done = 1'b0;
    rst      = 1'b1;

    // Reset state
    step(4'b0000, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b1);
    chk("reset_gnt", 32'(bus.gnt), 32'd0);

    // Single request, done after three held cycles
    step(4'b0100, 1'b0, 1'b0);
    chk("t1_gnt", 32'(bus.gnt), 32'h4);
    chk("t1_sel", 32'(bus.sel), 32'd2);
    step(4'b0100, 1'b0, 1'b0);
    step(4'b0100, 1'b0, 1'b0);
    step(4'b0100, 1'b1, 1'b0);
    chk("t1_rel_sel", 32'(bus.sel), 32'd2);
    step(4'b0000, 1'b0, 1'b0);

    // Wrap from ptr=3, done ignored while idle, other req bits ignored while busy
    step(4'b0000, 1'b1, 1'b0);
    step(4'b0011, 1'b0, 1'b0);
    chk("t6_wrap", 32'(bus.gnt), 32'h1);
    step(4'b0111, 1'b0, 1'b0);
    step(4'b0011, 1'b0, 1'b0);
    step(4'b0111, 1'b0, 1'b0);
    chk("t6_toggle", 32'(bus.gnt), 32'h1);
    step(4'b0000, 1'b0, 1'b0);

    // Round robin with all requesting
    step(4'b0000, 1'b0, 1'b1);
    for (int g = 0; g < 5; g++) begin
      step(4'b1111, 1'b0, 1'b0);
      chk("t2_order", 32'(bus.sel), 32'(g % 4));
      step(4'b1111, 1'b0, 1'b0);
      step(4'b1111, 1'b1, 1'b0);
      chk("t2_idle", 32'(bus.gnt), 32'd0);
    end
    step(4'b0000, 1'b0, 1'b0);

    // Hold timeout
    hi_cnt = 0;
    to_cnt = 0;
    for (int c = 0; c < MH + 1; c++) begin
      step(4'b0001, 1'b0, 1'b0);
      if (bus.gnt[0]) hi_cnt++;
      if (bus.timeout) to_cnt++;
    end
    chk("t3_hold_cycles", 32'(hi_cnt), 32'(MH));
    chk("t3_timeout_pulses", 32'(to_cnt), 32'd1);
    step(4'b0000, 1'b0, 1'b0);
    step(4'b0011, 1'b0, 1'b0);
    chk("t3_ptr_after", 32'(bus.gnt), 32'h2);
    step(4'b0000, 1'b0, 1'b0);

    // Abort on cycle 5
    step(4'b0010, 1'b0, 1'b0);
    for (int c = 0; c < 4; c++) step(4'b0010, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    chk("t4_abort_to", 32'(bus.timeout), 32'd0);

    // done on the last allowed cycle is a plain release
    step(4'b1000, 1'b0, 1'b0);
    for (int c = 0; c < MH - 1; c++) step(4'b1000, 1'b0, 1'b0);
    step(4'b1000, 1'b1, 1'b0);
    chk("t4_collide_to", 32'(bus.timeout), 32'd0);
    step(4'b0000, 1'b0, 1'b0);

    // Reset mid-grant
    step(4'b1000, 1'b0, 1'b0);
    step(4'b1000, 1'b0, 1'b0);
    chk("t5_busy3", 32'(bus.gnt), 32'h8);
    step(4'b1000, 1'b0, 1'b1);
    chk("t5_rst_sel", 32'(bus.sel), 32'd0);
    step(4'b1010, 1'b0, 1'b0);
    chk("t5_after_rst", 32'(bus.gnt), 32'h2);
    step(4'b0000, 1'b0, 1'b0);

    // Random traffic
    cur_req = 4'b0000;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 5) == 0) cur_req = 4'($urandom_range(0, 15));
      cur_done = ($urandom_range(0, 11) == 0);
      cur_rst  = ($urandom_range(0, 299) == 0);
      step(cur_req, cur_done, cur_rst);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Round-robin arbiter that shares one 32-bit memory/bus port between four requesters in the RV32I core: instruction fetch, load/store unit, debug port and a spare. It issues a one-hot grant and a 2-bit select that drives the port's 4:1 request mux. It holds each grant until the port signals completion, the requester withdraws, or a hold timeout expires.

Parameters:
MAX_HOLD, 16, maximum number of cycles one grant may be held before forced release. Legal range is 2..256.
CNT_W, $clog2(MAX_HOLD+1), width of the hold counter. Derived; do not override.

Ports:
clk  input  1  system clock; all logic is rising-edge.
rst  input  1  synchronous, active-high reset.
req  input  4  request vector; bit i is requester i. Level-sensitive; held high until served.
done  input  1  one-cycle pulse from the shared port: the current transaction is complete.
gnt  output  4  one-hot grant; all zero when idle.
sel  output  2  binary index of the granted requester; drives the mux select.
busy  output  1  high while a grant is active.
timeout  output  1  one-cycle pulse when a grant is force-released by MAX_HOLD.

Behaviour:
- Reset: the synchronous rst on the clk edge clears all state.
  - gnt=0, sel=0, busy=0, timeout=0.
  - Round-robin pointer ptr=0; hold counter=0; FSM=IDLE.
  - rst asserted mid-grant drops the grant on that edge. No timeout pulse is produced.
- The FSM has two states: IDLE and BUSY. All outputs are registered.
- IDLE:
  - If req==0, remain in IDLE.
  - Otherwise, select the first set bit of req searching from index ptr upward, wrapping 3->0.
  - On the next edge: gnt=onehot(k), sel=k, busy=1, counter=0, state->BUSY.
  - Latency from req sampled high (in IDLE) to gnt high is 1 cycle.
- BUSY, evaluated each cycle with k as the granted index:
  - done=1: release.
  - done=0 and req[k]=0: release (abort).
  - done=0, req[k]=1 and counter==MAX_HOLD-1: release and pulse timeout=1 for exactly one cycle.
  - Otherwise: counter+=1 and the grant is held.
  - Priority order is done > abort > timeout. done together with counter==MAX_HOLD-1 is a normal release with no timeout pulse.
- Release, applied on the edge:
  - gnt=0, busy=0, ptr=(k+1) mod 4, state->IDLE.
  - sel keeps the value k so the mux output stays stable.
  - At least one IDLE cycle separates consecutive grants. Arbitration happens only in IDLE.
- A grant therefore lasts at most MAX_HOLD cycles with gnt high.
- done while in IDLE is ignored.
- Changes to req bits other than k during BUSY have no effect.
- Fairness: with all four requesters continuously requesting, grants go 0,1,2,3,0,...; no requester waits more than 3 grants.
- Invariants:
  - gnt is always one-hot or zero.
  - busy == |gnt.
  - When busy=1, sel equals the index of the set gnt bit.
  - timeout is never high when busy is high on the same cycle.

Test Plan:
1. Reset, then req=4'b0100: the cycle after, gnt=4'b0100, sel=2, busy=1. done pulse 3 cycles later: next cycle gnt=0, busy=0, sel stays 2; ptr=3.
2. Round-robin: req=4'b1111 constant, with done pulsed 2 cycles into each grant. Grants must be 0,1,2,3,0 in order, each separated by exactly one idle cycle.
3. Timeout with MAX_HOLD=16: req=4'b0001 held, done never asserted. gnt stays high for exactly 16 cycles. timeout=1 for one cycle together with gnt going to 0; ptr=1.
4. Abort and collision:
   - Grant requester 1, then drop req[1] on cycle 5 with done=0: release with no timeout pulse.
   - Separately, assert done on the cycle counter==15: normal release, timeout stays 0.
5. Reset mid-grant: requester 3 is busy and rst is asserted. On the next edge gnt=0, sel=0, busy=0. With req=4'b1010 after reset, requester 1 wins because ptr=0.
6. Wrap and ignore:
   - ptr=3 with req=4'b0011: requester 0 is granted.
   - A done pulse while idle causes no state change.
   - Toggling req[2] during requester 0's grant does not affect gnt.
